// File: rtl/pipe_adder_if.sv
// Handshake/operand bundle for pipe_adder.
// Optional feature macro: PIPE_ADDER_SUB_EN adds the per-operand 'sub' select.
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef PIPE_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif
endinterface

// File: rtl/pipe_adder.sv
// Pipelined ripple-chunk adder: one CHUNK-bit adder per stage, carry
// registered between stages, global stall driven by the output handshake.
// Optional feature macro: PIPE_ADDER_SUB_EN (per-operand a - b via 'sub').
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // Stage source values (what stage k consumes this cycle)
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    logic [WIDTH-1:0] s_src   [STAGES];
    logic             c_src   [STAGES];
    logic             vld_src [STAGES];

    // Stage registers and their next-state values
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             vld_d [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // One CHUNK-wide slice of the sum; MSB of the result is the chunk carry.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Whole pipeline moves together; a held result freezes every stage.
    assign adv          = !vld_q[STAGES-1] || bus.out_ready;
    // Ready stays high through reset even if a stalled result was pending.
    assign bus.in_ready = adv || rst;

`ifdef PIPE_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the caller's cin is ignored in that mode.
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    // Route each stage's inputs: stage 0 from the bus, later stages from the previous register.
    always_comb begin
        a_src[0]   = bus.a;
        b_src[0]   = b_in;
        s_src[0]   = '0;
        c_src[0]   = c_in;
        vld_src[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            s_src[k]   = s_q[k-1];
            c_src[k]   = c_q[k-1];
            vld_src[k] = vld_q[k-1];
        end
    end

    // Each stage adds its own chunk; untouched upper operand bits and finished lower sum bits ride along.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_src[k];
            b_d[k]   = b_src[k];
            s_d[k]   = s_src[k];
            vld_d[k] = vld_src[k];
            {c_d[k], s_d[k][k*CHUNK +: CHUNK]} =
                chunk_add(a_src[k][k*CHUNK +: CHUNK], b_src[k][k*CHUNK +: CHUNK], c_src[k]);
        end
        // Operand sign bits are still present at the input of the last stage.
        ovf_d = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
                (s_d[STAGES-1][WIDTH-1]   != a_src[STAGES-1][WIDTH-1]);
    end

    // Stage registers: reset clears valids and the visible result; otherwise load on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
            s_q[STAGES-1] <= '0;
            c_q[STAGES-1] <= 1'b0;
            ovf_q         <= 1'b0;
        end else if (adv) begin
            // stage boundary k-1 -> k: all stages shift together
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;

endmodule
